// File: rtl/alu_issue_ctrl.sv
// RV32I issue controller: decodes one bundle, drives the external ALU,
// then registers the writeback/branch record behind a valid/ready handshake.
module alu_issue_ctrl #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    output logic [31:0] o_alu_x,
    output logic [31:0] o_alu_y,
    output logic [3:0]  o_alu_control,
    input  logic [31:0] i_alu_resultado,
    input  logic        i_alu_zero,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_rd_addr,
    output logic        o_wb_en,
    output logic        o_is_mem,
    output logic        o_br_taken,
    output logic [31:0] o_br_target,
    output logic        o_illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST = 3'(EXEC_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic        r_out_valid;
    logic        r_is_slt;
    logic        r_is_br;
    logic        r_br_eq;
    logic [31:0] r_alu_x;
    logic [31:0] r_alu_y;
    logic [3:0]  r_alu_ctl;
    logic [31:0] r_wb_data;
    logic [4:0]  r_rd;
    logic        r_wb_en;
    logic        r_is_mem;
    logic        r_br_taken;
    logic [31:0] r_br_target;
    logic        r_illegal;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic        w_op_reg;
    logic        w_op_imm;
    logic        w_op_load;
    logic        w_op_store;
    logic        w_op_br;
    logic        w_op_lui;
    logic        w_op_auipc;
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic [3:0]  w_ctl;
    logic        w_illegal;
    logic        w_is_slt;
    logic        w_is_br;
    logic        w_br_eq;
    logic        w_is_mem;
    logic        w_store;
    logic        w_wb_en;
    logic        w_accept;
    logic        w_f7_ok;
    logic        w_last;

    assign w_opcode   = i_instr[6:0];
    assign w_f3       = i_instr[14:12];
    assign w_f7       = i_instr[31:25];
    assign w_imm_i    = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s    = {{20{i_instr[31]}}, i_instr[31:25],
                         i_instr[11:7]};
    assign w_imm_b    = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u    = {i_instr[31:12], 12'b0};
    assign w_op_reg   = (w_opcode == 7'b0110011);
    assign w_op_imm   = (w_opcode == 7'b0010011);
    assign w_op_load  = (w_opcode == 7'b0000011);
    assign w_op_store = (w_opcode == 7'b0100011);
    assign w_op_br    = (w_opcode == 7'b1100011);
    assign w_op_lui   = (w_opcode == 7'b0110111);
    assign w_op_auipc = (w_opcode == 7'b0010111);
    // funct7=0100000 is only meaningful for SUB and SRA
    assign w_f7_ok    = (w_f7 == 7'h00) ||
                        (w_f7 == 7'h20 && (w_f3 == 3'b000 ||
                                           w_f3 == 3'b101));

    always_comb begin
        w_x       = i_rs1_data;
        w_y       = i_rs2_data;
        w_ctl     = 4'b0000;
        w_illegal = 1'b0;
        w_is_slt  = 1'b0;
        w_is_br   = 1'b0;
        w_br_eq   = 1'b0;
        w_is_mem  = 1'b0;
        w_store   = 1'b0;
        unique case (1'b1)
            w_op_reg: begin
                w_illegal = !w_f7_ok;
                case (w_f3)
                    3'b000: w_ctl = w_f7[5] ? 4'b0111 : 4'b0000;
                    3'b001: w_ctl = 4'b1000;
                    3'b010,
                    3'b011: begin
                        w_ctl    = 4'b0100;
                        w_is_slt = 1'b1;
                    end
                    3'b100: w_ctl = 4'b1001;
                    3'b101: w_ctl = w_f7[5] ? 4'b1110 : 4'b1010;
                    3'b110: w_ctl = 4'b0001;
                    default: w_ctl = 4'b0010;
                endcase
                if (w_f3 == 3'b001 || w_f3 == 3'b101)
                    w_y = {27'b0, i_rs2_data[4:0]};
            end
            w_op_imm: begin
                w_y = w_imm_i;
                case (w_f3)
                    3'b000: w_ctl = 4'b0000;
                    3'b001: begin
                        w_ctl     = 4'b1000;
                        w_y       = {27'b0, i_instr[24:20]};
                        w_illegal = (w_f7 != 7'h00);
                    end
                    3'b010,
                    3'b011: begin
                        w_ctl    = 4'b0100;
                        w_is_slt = 1'b1;
                    end
                    3'b100: w_ctl = 4'b1001;
                    3'b101: begin
                        w_ctl     = w_f7[5] ? 4'b1110 : 4'b1010;
                        w_y       = {27'b0, i_instr[24:20]};
                        w_illegal = (w_f7 != 7'h00) &&
                                    (w_f7 != 7'h20);
                    end
                    3'b110: w_ctl = 4'b0001;
                    default: w_ctl = 4'b0010;
                endcase
            end
            w_op_load: begin
                w_y       = w_imm_i;
                w_is_mem  = 1'b1;
                w_illegal = (w_f3 != 3'b010);
            end
            w_op_store: begin
                w_y       = w_imm_s;
                w_is_mem  = 1'b1;
                w_store   = 1'b1;
                w_illegal = (w_f3 != 3'b010);
            end
            w_op_br: begin
                w_is_br = 1'b1;
                case (w_f3)
                    3'b000: begin
                        w_ctl   = 4'b1111;
                        w_br_eq = 1'b1;
                    end
                    3'b001: begin
                        w_ctl   = 4'b0011;
                        w_br_eq = 1'b1;
                    end
                    3'b100, 3'b110: w_ctl = 4'b0100;
                    3'b101, 3'b111: w_ctl = 4'b1011;
                    default: w_illegal = 1'b1;
                endcase
            end
            w_op_lui: begin
                w_x   = 32'h0;
                w_y   = w_imm_u;
                w_ctl = 4'b0110;
            end
            w_op_auipc: begin
                w_x = i_pc;
                w_y = w_imm_u;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_wb_en  = !w_illegal && !w_store && !w_is_br &&
                      (i_instr[11:7] != 5'd0);
    assign w_accept = i_in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == LAST);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept)
                w_next = w_illegal ? S_DONE : S_EXEC;
            S_EXEC: if (w_last) w_next = S_DONE;
            S_DONE: if (r_out_valid && i_out_ready)
                w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_out_valid <= 1'b0;
            r_is_slt    <= 1'b0;
            r_is_br     <= 1'b0;
            r_br_eq     <= 1'b0;
            r_alu_x     <= 32'h0;
            r_alu_y     <= 32'h0;
            r_alu_ctl   <= 4'b0000;
            r_wb_data   <= 32'h0;
            r_rd        <= 5'd0;
            r_wb_en     <= 1'b0;
            r_is_mem    <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= 32'h0;
            r_illegal   <= 1'b0;
        end else begin
            r_state <= w_next;
            // first DONE cycle settles the record before it is offered
            r_out_valid <= (r_state == S_DONE) &&
                           !(r_out_valid && i_out_ready);
            if (w_accept) begin
                r_cnt       <= 3'd0;
                r_alu_x     <= w_x;
                r_alu_y     <= w_y;
                r_alu_ctl   <= w_ctl;
                r_is_slt    <= w_is_slt;
                r_is_br     <= w_is_br;
                r_br_eq     <= w_br_eq;
                r_rd        <= i_instr[11:7];
                r_wb_en     <= w_wb_en;
                r_is_mem    <= w_is_mem && !w_illegal;
                r_illegal   <= w_illegal;
                r_br_target <= i_pc + w_imm_b;
                r_wb_data   <= 32'h0;
                r_br_taken  <= 1'b0;
            end
            if (r_state == S_EXEC) begin
                r_cnt <= r_cnt + 3'd1;
                if (w_last) begin
                    r_wb_data  <= r_is_slt ?
                                  {31'b0, ~i_alu_zero} :
                                  i_alu_resultado;
                    r_br_taken <= r_is_br &&
                                  (r_br_eq ? i_alu_zero :
                                             ~i_alu_zero);
                end
            end
        end
    end

    assign o_in_ready    = (r_state == S_IDLE);
    assign o_out_valid   = r_out_valid;
    assign o_alu_x       = r_alu_x;
    assign o_alu_y       = r_alu_y;
    assign o_alu_control = r_alu_ctl;
    assign o_wb_data     = r_wb_data;
    assign o_rd_addr     = r_rd;
    assign o_wb_en       = r_wb_en;
    assign o_is_mem      = r_is_mem;
    assign o_br_taken    = r_br_taken;
    assign o_br_target   = r_br_target;
    assign o_illegal     = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with EXEC_CYCLES=1 and =3 instances,
// each paired with a behavioural ALU.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv = 1'b0;
    logic        ordy = 1'b0;
    int          sel = 1;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic [31:0] rs1 = 32'h0;
    logic [31:0] rs2 = 32'h0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] acc_x, acc_y;
    logic [3:0]  acc_ctl;

    logic        iv1, iv3, or1, or3;
    logic        d1_ir, d1_ov, d1_wben, d1_mem, d1_tk, d1_ill, d1_zero;
    logic        d3_ir, d3_ov, d3_wben, d3_mem, d3_tk, d3_ill, d3_zero;
    logic [31:0] d1_x, d1_y, d1_wb, d1_tgt, d1_res;
    logic [31:0] d3_x, d3_y, d3_wb, d3_tgt, d3_res;
    logic [3:0]  d1_ctl, d3_ctl;
    logic [4:0]  d1_rd, d3_rd;

    logic        m_ir, m_ov, m_wben, m_mem, m_tk, m_ill;
    logic [31:0] m_x, m_y, m_wb, m_tgt;
    logic [3:0]  m_ctl;
    logic [4:0]  m_rd;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [3:0] c);
        case (c)
            4'b0000: return x + y;
            4'b0111: return x - y;
            4'b0110: return y;
            4'b0010: return x & y;
            4'b0001: return x | y;
            4'b1001: return x ^ y;
            4'b1000: return x << y[4:0];
            4'b1010: return x >> y[4:0];
            4'b1110: return 32'($signed(x) >>> y[4:0]);
            4'b0100: return ($signed(x) < $signed(y)) ? 32'd0 : 32'd1;
            4'b1111: return (x == y) ? 32'd1 : 32'd0;
            4'b0011: return (x != y) ? 32'd1 : 32'd0;
            4'b1011: return ($signed(x) >= $signed(y)) ? 32'd0 : 32'd1;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7,
        input logic [4:0] b, input logic [4:0] a,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, b, a, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm,
        input logic [4:0] a, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] op);
        return {imm, a, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm,
        input logic [4:0] b, input logic [4:0] a,
        input logic [2:0] f3);
        return {imm[12], imm[10:5], b, a, f3, imm[4:1], imm[11],
                7'b1100011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm,
        input logic [4:0] b, input logic [4:0] a);
        return {imm[11:5], b, a, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    assign iv1 = iv && (sel == 1);
    assign iv3 = iv && (sel == 3);
    assign or1 = ordy && (sel == 1);
    assign or3 = ordy && (sel == 3);
    assign d1_res  = alu_f(d1_x, d1_y, d1_ctl);
    assign d1_zero = (d1_res != 32'h0);
    assign d3_res  = alu_f(d3_x, d3_y, d3_ctl);
    assign d3_zero = (d3_res != 32'h0);

    always_comb begin
        m_ir = d1_ir; m_ov = d1_ov; m_x = d1_x; m_y = d1_y;
        m_ctl = d1_ctl; m_wb = d1_wb; m_rd = d1_rd; m_wben = d1_wben;
        m_mem = d1_mem; m_tk = d1_tk; m_tgt = d1_tgt; m_ill = d1_ill;
        if (sel == 3) begin
            m_ir = d3_ir; m_ov = d3_ov; m_x = d3_x; m_y = d3_y;
            m_ctl = d3_ctl; m_wb = d3_wb; m_rd = d3_rd; m_wben = d3_wben;
            m_mem = d3_mem; m_tk = d3_tk; m_tgt = d3_tgt; m_ill = d3_ill;
        end
    end

    alu_issue_ctrl #(.EXEC_CYCLES(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(iv1), .o_in_ready(d1_ir),
        .i_instr(instr), .i_pc(pc), .i_rs1_data(rs1), .i_rs2_data(rs2),
        .o_alu_x(d1_x), .o_alu_y(d1_y), .o_alu_control(d1_ctl),
        .i_alu_resultado(d1_res), .i_alu_zero(d1_zero),
        .o_out_valid(d1_ov), .i_out_ready(or1), .o_wb_data(d1_wb),
        .o_rd_addr(d1_rd), .o_wb_en(d1_wben), .o_is_mem(d1_mem),
        .o_br_taken(d1_tk), .o_br_target(d1_tgt), .o_illegal(d1_ill)
    );

    alu_issue_ctrl #(.EXEC_CYCLES(3)) u_dut3 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(iv3), .o_in_ready(d3_ir),
        .i_instr(instr), .i_pc(pc), .i_rs1_data(rs1), .i_rs2_data(rs2),
        .o_alu_x(d3_x), .o_alu_y(d3_y), .o_alu_control(d3_ctl),
        .i_alu_resultado(d3_res), .i_alu_zero(d3_zero),
        .o_out_valid(d3_ov), .i_out_ready(or3), .o_wb_data(d3_wb),
        .o_rd_addr(d3_rd), .o_wb_en(d3_wben), .o_is_mem(d3_mem),
        .o_br_taken(d3_tk), .o_br_target(d3_tgt), .o_illegal(d3_ill)
    );

    task automatic issue(input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        @(negedge clk);
        instr = ins; pc = p; rs1 = a; rs2 = b; iv = 1'b1;
        checks++;
        if (m_ir !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: got %b want 1", m_ir);
        end
        @(posedge clk); #1;
        iv = 1'b0;
        acc_x = m_x; acc_y = m_y; acc_ctl = m_ctl;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!m_ov && lat < 30);
        if (!m_ov) begin
            checks++; errors++;
            $display("FAIL out_valid_timeout: got 0 want 1 within 30");
        end
    endtask

    task automatic release_rec();
        @(negedge clk);
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        checks++;
        if ({m_ov, m_ir} !== 2'b01) begin
            errors++;
            $display("FAIL release: got ov/ir=%b want 01", {m_ov, m_ir});
        end
    endtask

    task automatic test_reset();
        logic [142:0] got, want;
        sel = 1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got  = {m_ir, m_ov, m_x, m_y, m_ctl, m_wb, m_rd, m_wben,
                m_mem, m_tk, m_tgt, m_ill};
        want = {1'b1, 142'b0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", got, want);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_addi();
        int lat;
        sel = 1;
        issue(enc_i(12'hFFF, 5'd1, 3'b000, 5'd5, 7'b0010011),
              32'h0, 32'h0, 32'h0, lat);
        checks += 6;
        if (acc_ctl !== 4'b0000) begin
            errors++;
            $display("FAIL addi_ctl: got %b want 0000", acc_ctl);
        end
        if (acc_y !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL addi_y: got %h want ffffffff", acc_y);
        end
        if (lat !== 2) begin
            errors++;
            $display("FAIL addi_latency: got %0d want 2", lat);
        end
        if (m_wb !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL addi_wb: got %h want ffffffff", m_wb);
        end
        if (m_rd !== 5'd5) begin
            errors++;
            $display("FAIL addi_rd: got %0d want 5", m_rd);
        end
        if ({m_wben, m_ill, m_tk} !== 3'b100) begin
            errors++;
            $display("FAIL addi_flags: got %b want 100",
                     {m_wben, m_ill, m_tk});
        end
        release_rec();
    endtask

    task automatic test_slt();
        int lat;
        logic [31:0] ins;
        sel = 1;
        ins = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3);
        issue(ins, 32'h0, 32'd3, 32'd7, lat);
        checks += 2;
        if (acc_ctl !== 4'b0100) begin
            errors++;
            $display("FAIL slt_ctl: got %b want 0100", acc_ctl);
        end
        if (m_wb !== 32'd1) begin
            errors++;
            $display("FAIL slt_lt: got %h want 1", m_wb);
        end
        release_rec();
        issue(ins, 32'h0, 32'd7, 32'd3, lat);
        checks++;
        if (m_wb !== 32'd0) begin
            errors++;
            $display("FAIL slt_ge: got %h want 0", m_wb);
        end
        release_rec();
    endtask

    task automatic test_branch();
        int lat;
        sel = 1;
        issue(enc_b(13'd32, 5'd2, 5'd1, 3'b000), 32'hFFFFFFF0,
              32'h1234, 32'h1234, lat);
        checks += 3;
        if (m_tk !== 1'b1) begin
            errors++;
            $display("FAIL beq_taken: got %b want 1", m_tk);
        end
        if (m_tgt !== 32'h00000010) begin
            errors++;
            $display("FAIL beq_target: got %h want 00000010", m_tgt);
        end
        if (m_wben !== 1'b0) begin
            errors++;
            $display("FAIL beq_wben: got %b want 0", m_wben);
        end
        release_rec();
        issue(enc_b(13'd32, 5'd2, 5'd1, 3'b001), 32'hFFFFFFF0,
              32'h1234, 32'h1234, lat);
        checks++;
        if (m_tk !== 1'b0) begin
            errors++;
            $display("FAIL bne_taken: got %b want 0", m_tk);
        end
        release_rec();
    endtask

    task automatic test_backpressure();
        int lat;
        int n;
        sel = 1;
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd10), 32'h0,
              32'd5, 32'd6, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rs1 = 32'(i + 100);
            @(posedge clk); #1;
            checks++;
            if ({m_ov, m_ir, m_wb, m_x, m_rd} !==
                {1'b1, 1'b0, 32'd11, 32'd5, 5'd10}) begin
                errors++;
                $display("FAIL bp_hold%0d: got ov=%b ir=%b wb=%h x=%h rd=%0d want 1 0 0000000b 00000005 10",
                         i, m_ov, m_ir, m_wb, m_x, m_rd);
            end
        end
        @(negedge clk);
        ordy = 1'b1;
        iv = 1'b1;
        instr = enc_i(12'd9, 5'd1, 3'b000, 5'd6, 7'b0010011);
        rs1 = 32'd1;
        @(posedge clk); #1;
        ordy = 1'b0;
        checks++;
        if ({m_ov, m_ir} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: got ov/ir=%b want 01", {m_ov, m_ir});
        end
        @(posedge clk); #1;
        iv = 1'b0;
        checks++;
        if (m_ir !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_accept: got ir=%b want 0", m_ir);
        end
        n = 0;
        while (!m_ov && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (m_wb !== 32'd10) begin
            errors++;
            $display("FAIL bp_next_wb: got %h want 0000000a", m_wb);
        end
        release_rec();
    endtask

    typedef struct {
        logic [31:0] ins, p, a, b, wb;
        logic [3:0]  ctl;
        logic        wben, mem, tk, ill;
        int          lat;
    } vec_t;

    task automatic test_table();
        vec_t t[8];
        int lat;
        sel = 1;
        t[0] = '{32'h0000006F, 32'h0, 32'h0, 32'h0, 32'h0,
                 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        t[1] = '{{20'h12345, 5'd7, 7'b0110111}, 32'h0, 32'h0, 32'h0,
                 32'h12345000, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        t[2] = '{enc_i(12'h404, 5'd1, 3'b101, 5'd8, 7'b0010011), 32'h0,
                 32'h80000000, 32'h0, 32'hF8000000, 4'b1110,
                 1'b1, 1'b0, 1'b0, 1'b0, 2};
        t[3] = '{enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd9), 32'h0,
                 32'd10, 32'd3, 32'd7, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        t[4] = '{enc_b(13'd16, 5'd2, 5'd1, 3'b100), 32'h0,
                 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0100,
                 1'b0, 1'b0, 1'b1, 1'b0, 2};
        t[5] = '{enc_s(12'd8, 5'd2, 5'd1), 32'h0, 32'h100, 32'h55,
                 32'h108, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        t[6] = '{enc_i(12'h401, 5'd1, 3'b001, 5'd3, 7'b0010011), 32'h0,
                 32'h1, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        t[7] = '{{20'h00001, 5'd4, 7'b0010111}, 32'h1000, 32'h0, 32'h0,
                 32'h2000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        for (int i = 0; i < 8; i++) begin
            issue(t[i].ins, t[i].p, t[i].a, t[i].b, lat);
            checks++;
            if (lat !== t[i].lat || m_ill !== t[i].ill ||
                m_wben !== t[i].wben || m_mem !== t[i].mem ||
                m_tk !== t[i].tk || m_wb !== t[i].wb) begin
                errors++;
                $display("FAIL vec%0d: got lat=%0d ill=%b wen=%b mem=%b tk=%b wb=%h want %0d %b %b %b %b %h",
                         i, lat, m_ill, m_wben, m_mem, m_tk, m_wb,
                         t[i].lat, t[i].ill, t[i].wben, t[i].mem,
                         t[i].tk, t[i].wb);
            end
            if (!t[i].ill) begin
                checks++;
                if (acc_ctl !== t[i].ctl) begin
                    errors++;
                    $display("FAIL vec%0d_ctl: got %b want %b",
                             i, acc_ctl, t[i].ctl);
                end
            end
            release_rec();
        end
    endtask

    task automatic test_reset_mid_exec();
        int lat;
        logic [142:0] got, want;
        logic seen;
        sel = 3;
        @(negedge clk);
        instr = enc_i(12'd77, 5'd1, 3'b000, 5'd5, 7'b0010011);
        rs1 = 32'd1; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        got  = {m_ir, m_ov, m_x, m_y, m_ctl, m_wb, m_rd, m_wben,
                m_mem, m_tk, m_tgt, m_ill};
        want = {1'b1, 142'b0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL rst_exec_values: got %h want %h", got, want);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (m_ov || !m_ir) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_exec_quiet: got pulse/busy=1 want 0");
        end
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd12), 32'h0,
              32'd2, 32'd3, lat);
        checks += 2;
        if (lat !== 4) begin
            errors++;
            $display("FAIL e3_latency: got %0d want 4", lat);
        end
        if ({m_wb, m_rd, m_wben} !== {32'd5, 5'd12, 1'b1}) begin
            errors++;
            $display("FAIL e3_record: got wb=%h rd=%0d wen=%b want 00000005 12 1",
                     m_wb, m_rd, m_wben);
        end
        release_rec();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_slt();
        test_branch();
        test_backpressure();
        test_table();
        test_reset_mid_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
